// File: rtl/sd_bridge_pkg.sv
// rtl/sd_bridge_pkg.sv - shared state type and sector geometry for the SD sector bridge
package sd_bridge_pkg;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_REQ, S_RUN} state_t;

  localparam int SECTOR_BYTES = 512;
  localparam int SECTOR_WORDS = 256;
  localparam int WORD_AW      = $clog2(SECTOR_WORDS);
  localparam int BYTE_AW      = $clog2(SECTOR_BYTES);

endpackage

// File: rtl/sd_sector_bridge_if.sv
// rtl/sd_sector_bridge_if.sv - host command handshake and 16-bit word port of the bridge
interface sd_sector_bridge_if;
  import sd_bridge_pkg::*;

  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_write;
  logic [31:0]        cmd_lba;
  logic               done;
  logic               err;
  logic [WORD_AW-1:0] host_addr;
  logic               host_we;
  logic [15:0]        host_wdata;
  logic [15:0]        host_rdata;

  modport master (
    output cmd_valid, cmd_write, cmd_lba, host_addr, host_we, host_wdata,
    input  cmd_ready, done, err, host_rdata
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_lba, host_addr, host_we, host_wdata,
    output cmd_ready, done, err, host_rdata
  );

endinterface

// File: rtl/sd_buf_bank.sv
// rtl/sd_buf_bank.sv - 256x8 single-port RAM with registered read (read-before-write)
module sd_buf_bank
  import sd_bridge_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  input  logic               we,
  input  logic [WORD_AW-1:0] addr,
  input  logic [7:0]         wdata,
  output logic [7:0]         rdata
);

  logic [7:0] mem [SECTOR_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rdata <= '0;
    else       rdata <= mem[addr];
  end

endmodule

// File: rtl/sd_sector_bridge.sv
// rtl/sd_sector_bridge.sv - host front end for sd_rw: command FSM plus one-sector word buffer
// SD_BRIDGE_BYTESWAP_EN: host words map big-endian onto sector bytes (default little-endian).
module sd_sector_bridge
  import sd_bridge_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYC = 32'd50_000_000,
  parameter logic [31:0] LBA_OFFSET  = 32'd0
) (
  input  logic               clk,
  input  logic               rstn,
  sd_sector_bridge_if.slave  host,
  input  logic               sd_init,
  input  logic               sd_rbusy,
  input  logic               sd_rdone,
  output logic               sd_rstart,
  output logic               sd_wstart,
  output logic [31:0]        sd_sector,
  input  logic               sd_outen,
  input  logic [BYTE_AW-1:0] sd_outaddr,
  input  logic [7:0]         sd_outbyte,
  output logic [7:0]         sd_inbyte
);

  state_t      state;
  logic        wr_q;
  logic        rdone_seen;
  logic [31:0] timer;
  logic        timeout_hit;
  logic        sd_side;

  assign host.cmd_ready = (state == S_IDLE) && !sd_rbusy;
  assign timeout_hit    = (timer == TIMEOUT_CYC - 32'd1);
  assign sd_side        = (state == S_REQ) || (state == S_RUN);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_INIT;
      wr_q       <= 1'b0;
      rdone_seen <= 1'b0;
      timer      <= '0;
      sd_sector  <= '0;
      sd_rstart  <= 1'b0;
      sd_wstart  <= 1'b0;
      host.done  <= 1'b0;
      host.err   <= 1'b0;
    end else begin
      host.done <= 1'b0;
      host.err  <= 1'b0;
      case (state)
        S_INIT: if (sd_init) state <= S_IDLE;
        S_IDLE: begin
          if (host.cmd_valid && host.cmd_ready) begin
            wr_q       <= host.cmd_write;
            sd_sector  <= host.cmd_lba + LBA_OFFSET;
            sd_rstart  <= !host.cmd_write;
            sd_wstart  <= host.cmd_write;
            timer      <= '0;
            rdone_seen <= 1'b0;
            state      <= S_REQ;
          end
        end
        S_REQ: begin
          timer <= timer + 32'd1;
          if (timeout_hit) begin
            sd_rstart <= 1'b0;
            sd_wstart <= 1'b0;
            host.done <= 1'b1;
            host.err  <= 1'b1;
            state     <= S_IDLE;
          end else if (sd_rbusy) begin
            sd_rstart <= 1'b0;
            sd_wstart <= 1'b0;
            state     <= S_RUN;
          end
        end
        S_RUN: begin
          timer      <= timer + 32'd1;
          rdone_seen <= rdone_seen | sd_rdone;
          if (timeout_hit) begin
            host.done <= 1'b1;
            host.err  <= 1'b1;
            state     <= S_IDLE;
          end else if (!sd_rbusy) begin
            // sd_rw never retries a write, so a missing rdone is a hard error
            host.done <= 1'b1;
            host.err  <= wr_q && !(rdone_seen || sd_rdone);
            state     <= S_IDLE;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

  logic [WORD_AW-1:0] bank_addr;
  logic               we_even, we_odd;
  logic [7:0]         wd_even, wd_odd;
  logic [7:0]         rd_even, rd_odd;
  logic [7:0]         host_even, host_odd;
  logic               sel_odd_q;

`ifdef SD_BRIDGE_BYTESWAP_EN
  assign host_even       = host.host_wdata[15:8];
  assign host_odd        = host.host_wdata[7:0];
  assign host.host_rdata = {rd_even, rd_odd};
`else
  assign host_even       = host.host_wdata[7:0];
  assign host_odd        = host.host_wdata[15:8];
  assign host.host_rdata = {rd_odd, rd_even};
`endif

  // SD engine owns the RAM while a command is in flight; host writes then fall away
  always_comb begin
    bank_addr = host.host_addr;
    we_even   = host.host_we;
    we_odd    = host.host_we;
    wd_even   = host_even;
    wd_odd    = host_odd;
    if (sd_side) begin
      bank_addr = sd_outaddr[BYTE_AW-1:1];
      we_even   = sd_outen && !sd_outaddr[0];
      we_odd    = sd_outen && sd_outaddr[0];
      wd_even   = sd_outbyte;
      wd_odd    = sd_outbyte;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sel_odd_q <= 1'b0;
    else       sel_odd_q <= sd_outaddr[0];
  end

  assign sd_inbyte = sel_odd_q ? rd_odd : rd_even;

  sd_buf_bank u_even (
    .clk   (clk),
    .rstn  (rstn),
    .we    (we_even),
    .addr  (bank_addr),
    .wdata (wd_even),
    .rdata (rd_even)
  );

  sd_buf_bank u_odd (
    .clk   (clk),
    .rstn  (rstn),
    .we    (we_odd),
    .addr  (bank_addr),
    .wdata (wd_odd),
    .rdata (rd_odd)
  );

endmodule

// File: tb/tb_sd_sector_bridge.sv
// tb/tb_sd_sector_bridge.sv - randomized self-checking bench with an sd_rw stand-in and sector model
module tb_sd_sector_bridge;

  localparam logic [31:0] TO  = 32'd1000;
  localparam logic [31:0] OFS = 32'd2048;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        sd_init = 1'b0;
  logic        sd_rbusy = 1'b0;
  logic        sd_rdone = 1'b0;
  logic        sd_outen = 1'b0;
  logic [8:0]  sd_outaddr = '0;
  logic [7:0]  sd_outbyte = '0;
  logic        sd_rstart, sd_wstart;
  logic [31:0] sd_sector;
  logic [7:0]  sd_inbyte;

  int checks = 0;
  int errors = 0;

  logic [7:0] ref_buf [512];

  sd_sector_bridge_if bus ();

  sd_sector_bridge #(.TIMEOUT_CYC(TO), .LBA_OFFSET(OFS)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .host       (bus),
    .sd_init    (sd_init),
    .sd_rbusy   (sd_rbusy),
    .sd_rdone   (sd_rdone),
    .sd_rstart  (sd_rstart),
    .sd_wstart  (sd_wstart),
    .sd_sector  (sd_sector),
    .sd_outen   (sd_outen),
    .sd_outaddr (sd_outaddr),
    .sd_outbyte (sd_outbyte),
    .sd_inbyte  (sd_inbyte)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] exp_word(int w);
`ifdef SD_BRIDGE_BYTESWAP_EN
    return {ref_buf[2*w], ref_buf[2*w+1]};
`else
    return {ref_buf[2*w+1], ref_buf[2*w]};
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input int w, input logic [15:0] d);
    bus.host_addr  = w[7:0];
    bus.host_wdata = d;
    bus.host_we    = 1'b1;
    tick();
    bus.host_we    = 1'b0;
`ifdef SD_BRIDGE_BYTESWAP_EN
    ref_buf[2*w]   = d[15:8];
    ref_buf[2*w+1] = d[7:0];
`else
    ref_buf[2*w]   = d[7:0];
    ref_buf[2*w+1] = d[15:8];
`endif
  endtask

  task automatic issue_cmd(input logic wr, input logic [31:0] lba);
    logic [31:0] exp_sec;
    int n;
    n = 0;
    exp_sec = lba + OFS;
    while (bus.cmd_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_ready_wait: cmd_ready=%b required 1", bus.cmd_ready);
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_lba   = lba;
    tick();
    bus.cmd_valid = 1'b0;
    checks++;
    if (sd_rstart !== !wr || sd_wstart !== wr || sd_sector !== exp_sec) begin
      errors++;
      $display("FAIL cmd_start: rstart=%b wstart=%b sector=%h required rstart=%b wstart=%b sector=%h",
               sd_rstart, sd_wstart, sd_sector, !wr, wr, exp_sec);
    end
  endtask

  task automatic sd_begin(input logic wr);
    int d;
    d = $urandom_range(0, 3);
    repeat (d) tick();
    checks++;
    if (sd_rstart !== !wr || sd_wstart !== wr) begin
      errors++;
      $display("FAIL start_hold: rstart=%b wstart=%b required %b/%b", sd_rstart, sd_wstart, !wr, wr);
    end
    sd_rbusy = 1'b1;
    tick();
    checks++;
    if (sd_rstart !== 1'b0 || sd_wstart !== 1'b0) begin
      errors++;
      $display("FAIL start_drop: rstart=%b wstart=%b required 0/0", sd_rstart, sd_wstart);
    end
  endtask

  task automatic sd_end(input logic give_rdone, input logic exp_err);
    if (give_rdone) begin
      sd_rdone = 1'b1;
      tick();
      sd_rdone = 1'b0;
    end
    repeat ($urandom_range(0, 2)) tick();
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL done_early: done=%b required 0", bus.done);
    end
    sd_rbusy = 1'b0;
    tick();
    checks++;
    if (bus.done !== 1'b1 || bus.err !== exp_err) begin
      errors++;
      $display("FAIL cmd_done: done=%b err=%b required 1/%b", bus.done, bus.err, exp_err);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: done=%b required 0", bus.done);
    end
  endtask

  task automatic stream_read();
    for (int i = 0; i < 512; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        sd_outen = 1'b0;
        tick();
      end
      sd_outen   = 1'b1;
      sd_outaddr = i[8:0];
      sd_outbyte = ref_buf[i];
      tick();
    end
    sd_outen = 1'b0;
  endtask

  task automatic check_all_words(input string tag);
    for (int w = 0; w < 256; w++) begin
      bus.host_addr = w[7:0];
      tick();
      checks++;
      if (bus.host_rdata !== exp_word(w)) begin
        errors++;
        $display("FAIL %s word %0d: host_rdata=%h required %h", tag, w, bus.host_rdata, exp_word(w));
      end
    end
  endtask

  task automatic test_reset();
    int early;
    early = 0;
    repeat (3) tick();
    checks++;
    if (bus.cmd_ready !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0 || sd_rstart !== 1'b0 ||
        sd_wstart !== 1'b0 || sd_sector !== 32'd0 || bus.host_rdata !== 16'd0 || sd_inbyte !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b done=%b err=%b rs=%b ws=%b sec=%h rdata=%h inbyte=%h required all 0",
               bus.cmd_ready, bus.done, bus.err, sd_rstart, sd_wstart, sd_sector, bus.host_rdata, sd_inbyte);
    end
    rstn = 1'b1;
    repeat (10) begin
      tick();
      if (bus.cmd_ready !== 1'b0 || sd_rstart !== 1'b0 || sd_wstart !== 1'b0) early++;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL pre_init_idle: %0d cycles with outputs active, required 0", early);
    end
    sd_init = 1'b1;
    #1;
    checks++;
    if (bus.cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL init_same_cycle: cmd_ready=%b required 0", bus.cmd_ready);
    end
    tick();
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL init_ready: cmd_ready=%b required 1", bus.cmd_ready);
    end
  endtask

  task automatic test_read_basic();
    for (int i = 0; i < 512; i++) ref_buf[i] = i[7:0];
    issue_cmd(1'b0, 32'd5);
    checks++;
    if (sd_sector !== 32'd2053) begin
      errors++;
      $display("FAIL read_sector: sd_sector=%0d required 2053", sd_sector);
    end
    sd_begin(1'b0);
    stream_read();
    sd_end(1'b1, 1'b0);
    check_all_words("read_basic");
  endtask

  task automatic test_read_random();
    logic [31:0] lba;
    for (int i = 0; i < 512; i++) ref_buf[i] = 8'($urandom);
    lba = 32'hFFFF_F400 + $urandom_range(0, 4095);
    issue_cmd(1'b0, lba);
    sd_begin(1'b0);
    stream_read();
    sd_end($urandom_range(0, 1) == 1, 1'b0);
    check_all_words("read_random");
  endtask

  task automatic test_host_port();
    int w;
    logic [15:0] old_w, new_w;
    for (int k = 0; k < 256; k++) host_write(k, 16'hA500 | 16'(k));
    w = $urandom_range(2, 255);
    old_w = exp_word(w);
    new_w = ~old_w;
    bus.host_addr  = w[7:0];
    bus.host_wdata = new_w;
    bus.host_we    = 1'b1;
    tick();
    bus.host_we = 1'b0;
    checks++;
    if (bus.host_rdata !== old_w) begin
      errors++;
      $display("FAIL rw_collision: host_rdata=%h required old %h", bus.host_rdata, old_w);
    end
    tick();
    checks++;
    if (bus.host_rdata !== new_w) begin
      errors++;
      $display("FAIL rw_after: host_rdata=%h required %h", bus.host_rdata, new_w);
    end
    host_write(w, 16'hA500 | 16'(w));
  endtask

  task automatic test_write_cmd();
    int a;
    issue_cmd(1'b1, $urandom);
    sd_begin(1'b1);
    for (int n = 0; n < 80; n++) begin
      a = (n == 0) ? 3 : (n == 1) ? 0 : (n == 2) ? 511 : $urandom_range(0, 511);
      sd_outaddr = a[8:0];
      tick();
      checks++;
      if (sd_inbyte !== ref_buf[a]) begin
        errors++;
        $display("FAIL inbyte addr %0d: sd_inbyte=%h required %h", a, sd_inbyte, ref_buf[a]);
      end
    end
    sd_end(1'b1, 1'b0);
  endtask

  task automatic test_write_error();
    issue_cmd(1'b1, $urandom);
    sd_begin(1'b1);
    repeat ($urandom_range(1, 5)) tick();
    sd_end(1'b0, 1'b1);
  endtask

  task automatic test_timeout();
    int n, busy_bad;
    n = 0;
    busy_bad = 0;
    issue_cmd(1'b0, $urandom);
    while (bus.done !== 1'b1 && n < 2000) begin
      if (n == 3) sd_rbusy = 1'b1;
      tick();
      n++;
    end
    checks++;
    if (n != 1000 || bus.err !== 1'b1 || sd_rstart !== 1'b0) begin
      errors++;
      $display("FAIL timeout: done after %0d cycles err=%b rstart=%b required 1000 cycles err=1 rstart=0",
               n, bus.err, sd_rstart);
    end
    repeat (20) begin
      tick();
      if (bus.cmd_ready !== 1'b0) busy_bad++;
    end
    checks++;
    if (busy_bad != 0) begin
      errors++;
      $display("FAIL timeout_ready_hold: cmd_ready high %0d cycles while rbusy, required 0", busy_bad);
    end
    sd_rbusy = 1'b0;
    #1;
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL timeout_ready_release: cmd_ready=%b required 1", bus.cmd_ready);
    end
  endtask

  task automatic test_we_during_run();
    for (int i = 0; i < 512; i++) ref_buf[i] = 8'($urandom);
    issue_cmd(1'b0, $urandom);
    bus.host_addr  = 8'd0;
    bus.host_wdata = ~exp_word(0);
    bus.host_we    = 1'b1;
    sd_begin(1'b0);
    stream_read();
    bus.host_we = 1'b0;
    sd_end(1'b1, 1'b0);
    bus.host_addr = 8'd0;
    tick();
    checks++;
    if (bus.host_rdata !== exp_word(0)) begin
      errors++;
      $display("FAIL we_in_run: word0=%h required %h", bus.host_rdata, exp_word(0));
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    bad = 0;
    issue_cmd(1'b0, $urandom);
    sd_rbusy = 1'b1;
    tick();
    rstn     = 1'b0;
    sd_init  = 1'b0;
    sd_rbusy = 1'b0;
    #1;
    checks++;
    if (sd_rstart !== 1'b0 || bus.cmd_ready !== 1'b0 || sd_sector !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid: rstart=%b ready=%b sector=%h required 0/0/0", sd_rstart, bus.cmd_ready, sd_sector);
    end
    tick();
    rstn = 1'b1;
    repeat (4) begin
      tick();
      if (bus.cmd_ready !== 1'b0) bad++;
    end
    sd_init = 1'b1;
    tick();
    checks++;
    if (bad != 0 || bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_reinit: early_ready=%0d ready=%b required 0 and 1", bad, bus.cmd_ready);
    end
  endtask

  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_write  = 1'b0;
    bus.cmd_lba    = '0;
    bus.host_addr  = '0;
    bus.host_we    = 1'b0;
    bus.host_wdata = '0;
    test_reset();
    test_read_basic();
    test_read_random();
    test_host_port();
    test_write_cmd();
    test_write_error();
    test_timeout();
    test_we_during_run();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
